// File: rtl/mvu_pkg.sv
// Shared types and helpers for the MVU PE fold accumulator.
package mvu_pkg;

  typedef enum logic [0:0] {
    ACC = 1'b0,
    OUT = 1'b1
  } mvu_acc_state_t;

  // Width of fold_idx; one bit minimum so SF == 1 still has a legal vector.
  function automatic int unsigned fold_w(input int unsigned sf);
    return (sf > 1) ? $clog2(sf) : 1;
  endfunction

endpackage

// File: rtl/mvu_pe_acc_ctrl_if.sv
// Partial-sum input and result output handshake bundle of the PE accumulator.
interface mvu_pe_acc_ctrl_if
  import mvu_pkg::*;
#(
  parameter int unsigned TI = 10,
  parameter int unsigned TO = 16,
  parameter int unsigned SF = 4
);
  localparam int unsigned FW = fold_w(SF);

  logic                 in_v;
  logic                 in_rdy;
  logic signed [TI-1:0] in_sum;
  logic                 out_v;
  logic                 out_rdy;
  logic signed [TO-1:0] out_acc;
  logic [FW-1:0]        fold_idx;
  logic                 busy;

  // Accumulator side.
  modport slave (
    input  in_v, in_sum, out_rdy,
    output in_rdy, out_v, out_acc, fold_idx, busy
  );

  // Adder tree / output stage side.
  modport master (
    output in_v, in_sum, out_rdy,
    input  in_rdy, out_v, out_acc, fold_idx, busy
  );
endinterface

// File: rtl/mvu_pe_acc_add.sv
// TO-bit signed adder; saturating when MVU_PE_ACC_SAT_EN is defined, wrapping otherwise.
module mvu_pe_acc_add #(
  parameter int unsigned TO = 16
) (
  input  logic signed [TO-1:0] a_i,
  input  logic signed [TO-1:0] b_i,
  output logic signed [TO-1:0] sum_o
);

`ifdef MVU_PE_ACC_SAT_EN
  logic signed [TO:0] wide;

  always_comb begin
    wide = {a_i[TO-1], a_i} + {b_i[TO-1], b_i};
    // Overflow iff the guard bit disagrees with the result sign bit.
    if (wide[TO] != wide[TO-1]) begin
      sum_o = wide[TO] ? {1'b1, {(TO-1){1'b0}}} : {1'b0, {(TO-1){1'b1}}};
    end else begin
      sum_o = wide[TO-1:0];
    end
  end
`else
  always_comb begin
    sum_o = a_i + b_i;
  end
`endif

endmodule

// File: rtl/mvu_pe_acc_ctrl.sv
// Fold sequencer and accumulator after the PE adder tree.
// Optional build macro: MVU_PE_ACC_SAT_EN (saturating accumulation).
module mvu_pe_acc_ctrl
  import mvu_pkg::*;
#(
  parameter int unsigned TI = 10,
  parameter int unsigned TO = 16,
  parameter int unsigned SF = 4
) (
  input  logic               aclk,
  input  logic               rst,
  mvu_pe_acc_ctrl_if.slave   s
);
  localparam int unsigned   FW      = fold_w(SF);
  localparam logic [FW-1:0] LastIdx = FW'(SF - 1);

  mvu_acc_state_t       state_q, state_d;
  logic [FW-1:0]        fold_q, fold_d;
  logic signed [TO-1:0] acc_q, acc_d;
  logic signed [TI-1:0] in_sum_w;
  logic signed [TO-1:0] ext_sum;
  logic signed [TO-1:0] add_sum;
  logic                 accept;
  logic                 rdy;

  assign in_sum_w = s.in_sum;
  assign ext_sum  = TO'(in_sum_w);

  mvu_pe_acc_add #(
    .TO (TO)
  ) u_add (
    .a_i   (acc_q),
    .b_i   (ext_sum),
    .sum_o (add_sum)
  );

  always_comb begin
    state_d = state_q;
    fold_d  = fold_q;
    acc_d   = acc_q;
    // A held result frees the slot in the same cycle it is taken.
    rdy     = (state_q == ACC) | s.out_rdy;
    accept  = s.in_v & rdy;

    if ((state_q == OUT) && s.out_rdy) begin
      state_d = ACC;
    end

    if (accept) begin
      acc_d = (fold_q == '0) ? ext_sum : add_sum;
      if (fold_q == LastIdx) begin
        fold_d  = '0;
        state_d = OUT;
      end else begin
        fold_d = fold_q + FW'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q <= ACC;
      fold_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      fold_q  <= fold_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    s.in_rdy   = rdy;
    s.out_v    = (state_q == OUT);
    s.out_acc  = acc_q;
    s.fold_idx = fold_q;
    s.busy     = (fold_q != '0) | (state_q == OUT);
  end

endmodule

// File: tb/tb_mvu_pe_acc_ctrl.sv
// Directed bench for mvu_pe_acc_ctrl: SF=4 at TO=16/12/11 on shared stimulus, plus SF=1.
module tb_mvu_pe_acc_ctrl;
  import mvu_pkg::*;

  logic aclk = 1'b0;
  logic rst  = 1'b1;
  always #5 aclk = ~aclk;

  logic              in_v    = 1'b0;
  logic signed [9:0] in_sum  = '0;
  logic              out_rdy = 1'b1;
  logic              d_v     = 1'b0;
  logic signed [9:0] d_sum   = '0;
  logic              d_ordy  = 1'b1;

  mvu_pe_acc_ctrl_if #(.TI(10), .TO(16), .SF(4)) if_a ();
  mvu_pe_acc_ctrl_if #(.TI(10), .TO(12), .SF(4)) if_b ();
  mvu_pe_acc_ctrl_if #(.TI(10), .TO(11), .SF(4)) if_c ();
  mvu_pe_acc_ctrl_if #(.TI(10), .TO(16), .SF(1)) if_d ();

  assign if_a.in_v = in_v;  assign if_a.in_sum = in_sum;  assign if_a.out_rdy = out_rdy;
  assign if_b.in_v = in_v;  assign if_b.in_sum = in_sum;  assign if_b.out_rdy = out_rdy;
  assign if_c.in_v = in_v;  assign if_c.in_sum = in_sum;  assign if_c.out_rdy = out_rdy;
  assign if_d.in_v = d_v;   assign if_d.in_sum = d_sum;   assign if_d.out_rdy = d_ordy;

  mvu_pe_acc_ctrl #(.TI(10), .TO(16), .SF(4)) dut_a (.aclk(aclk), .rst(rst), .s(if_a.slave));
  mvu_pe_acc_ctrl #(.TI(10), .TO(12), .SF(4)) dut_b (.aclk(aclk), .rst(rst), .s(if_b.slave));
  mvu_pe_acc_ctrl #(.TI(10), .TO(11), .SF(4)) dut_c (.aclk(aclk), .rst(rst), .s(if_c.slave));
  mvu_pe_acc_ctrl #(.TI(10), .TO(16), .SF(1)) dut_d (.aclk(aclk), .rst(rst), .s(if_d.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge; outputs are then sampled at #1.
  task automatic drive(input logic v, input int s, input logic o);
    @(negedge aclk);
    in_v    = v;
    in_sum  = 10'(s);
    out_rdy = o;
    #1;
  endtask

  typedef struct {
    logic v; int s; logic o;
    logic rdy; logic ov; int acc; int fold; logic busy;
  } vec_t;

  vec_t tbl[25];

  int exp_c_pos, exp_c_neg;

  initial begin
    // Inputs and the outputs expected before the rising edge that samples them.
    tbl[0]  = '{1'b1,    1, 1'b1, 1'b1, 1'b0,     0, 0, 1'b0};
    tbl[1]  = '{1'b1,    2, 1'b1, 1'b1, 1'b0,     1, 1, 1'b1};
    tbl[2]  = '{1'b1,    3, 1'b1, 1'b1, 1'b0,     3, 2, 1'b1};
    tbl[3]  = '{1'b1,    4, 1'b1, 1'b1, 1'b0,     6, 3, 1'b1};
    tbl[4]  = '{1'b1,    2, 1'b1, 1'b1, 1'b1,    10, 0, 1'b1};
    tbl[5]  = '{1'b1,    2, 1'b1, 1'b1, 1'b0,     2, 1, 1'b1};
    tbl[6]  = '{1'b1,    2, 1'b1, 1'b1, 1'b0,     4, 2, 1'b1};
    tbl[7]  = '{1'b1,    2, 1'b1, 1'b1, 1'b0,     6, 3, 1'b1};
    tbl[8]  = '{1'b1,    7, 1'b0, 1'b0, 1'b1,     8, 0, 1'b1};
    tbl[9]  = '{1'b1,    7, 1'b0, 1'b0, 1'b1,     8, 0, 1'b1};
    tbl[10] = '{1'b1,    7, 1'b0, 1'b0, 1'b1,     8, 0, 1'b1};
    tbl[11] = '{1'b1,    7, 1'b0, 1'b0, 1'b1,     8, 0, 1'b1};
    tbl[12] = '{1'b1,    7, 1'b0, 1'b0, 1'b1,     8, 0, 1'b1};
    tbl[13] = '{1'b1,    5, 1'b1, 1'b1, 1'b1,     8, 0, 1'b1};
    tbl[14] = '{1'b1,    5, 1'b1, 1'b1, 1'b0,     5, 1, 1'b1};
    tbl[15] = '{1'b1,    5, 1'b1, 1'b1, 1'b0,    10, 2, 1'b1};
    tbl[16] = '{1'b1,    5, 1'b1, 1'b1, 1'b0,    15, 3, 1'b1};
    tbl[17] = '{1'b0,   99, 1'b0, 1'b0, 1'b1,    20, 0, 1'b1};
    tbl[18] = '{1'b0,    0, 1'b1, 1'b1, 1'b1,    20, 0, 1'b1};
    tbl[19] = '{1'b1, -512, 1'b1, 1'b1, 1'b0,    20, 0, 1'b0};
    tbl[20] = '{1'b1, -512, 1'b1, 1'b1, 1'b0,  -512, 1, 1'b1};
    tbl[21] = '{1'b1, -512, 1'b1, 1'b1, 1'b0, -1024, 2, 1'b1};
    tbl[22] = '{1'b1, -512, 1'b1, 1'b1, 1'b0, -1536, 3, 1'b1};
    tbl[23] = '{1'b0,    0, 1'b1, 1'b1, 1'b1, -2048, 0, 1'b1};
    tbl[24] = '{1'b0,    0, 1'b1, 1'b1, 1'b0, -2048, 0, 1'b0};

`ifdef MVU_PE_ACC_SAT_EN
    exp_c_pos = 1023;
    exp_c_neg = -1024;
`else
    exp_c_pos = -4;
    exp_c_neg = 0;
`endif

    repeat (2) @(negedge aclk);
    rst = 1'b0;

    // Reset state, basic fold, no-bubble restart, back-pressure, negative fold.
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].o);
      chk($sformatf("row%0d in_rdy", i),   int'(if_a.in_rdy),   int'(tbl[i].rdy));
      chk($sformatf("row%0d out_v", i),    int'(if_a.out_v),    int'(tbl[i].ov));
      chk($sformatf("row%0d out_acc", i),  int'(if_a.out_acc),  tbl[i].acc);
      chk($sformatf("row%0d fold_idx", i), int'(if_a.fold_idx), tbl[i].fold);
      chk($sformatf("row%0d busy", i),     int'(if_a.busy),     int'(tbl[i].busy));
    end

    // Width boundaries: 511 x4 and -512 x4 at TO = 16, 12, 11.
    repeat (4) drive(1'b1, 511, 1'b1);
    drive(1'b0, 0, 1'b1);
    chk("ovf_pos out_v16", int'(if_a.out_v), 1);
    chk("ovf_pos acc16", int'(if_a.out_acc), 2044);
    chk("ovf_pos acc12", int'(if_b.out_acc), 2044);
    chk("ovf_pos acc11", int'(if_c.out_acc), exp_c_pos);
    repeat (4) drive(1'b1, -512, 1'b1);
    drive(1'b0, 0, 1'b1);
    chk("ovf_neg out_v12", int'(if_b.out_v), 1);
    chk("ovf_neg acc16", int'(if_a.out_acc), -2048);
    chk("ovf_neg acc12", int'(if_b.out_acc), -2048);
    chk("ovf_neg acc11", int'(if_c.out_acc), exp_c_neg);

    // Reset after two of four beats.
    drive(1'b1, 9, 1'b1);
    drive(1'b1, 9, 1'b1);
    chk("pre_rst fold_idx", int'(if_a.fold_idx), 1);
    @(negedge aclk);
    rst  = 1'b1;
    in_v = 1'b0;
    @(negedge aclk);
    rst = 1'b0;
    #1;
    chk("rst fold_idx", int'(if_a.fold_idx), 0);
    chk("rst out_v", int'(if_a.out_v), 0);
    chk("rst busy", int'(if_a.busy), 0);
    chk("rst out_acc", int'(if_a.out_acc), 0);
    repeat (4) drive(1'b1, 1, 1'b1);
    drive(1'b0, 0, 1'b1);
    chk("post_rst out_v", int'(if_a.out_v), 1);
    chk("post_rst out_acc", int'(if_a.out_acc), 4);
    drive(1'b0, 0, 1'b1);
    chk("post_rst drained", int'(if_a.out_v), 0);

    // SF=1 streaming with random back-pressure against a small scoreboard.
    begin
      int   q[$];
      int   sent = 0;
      int   got  = 0;
      int   val;
      logic exp_ov = 1'b0;
      logic acc_now;
      for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
        @(negedge aclk);
        val    = sent * 73 - 250;
        d_v    = (sent < 8);
        d_sum  = 10'(val);
        d_ordy = 1'($urandom_range(0, 1));
        #1;
        chk("sf1 out_v", int'(if_d.out_v), int'(exp_ov));
        chk("sf1 in_rdy", int'(if_d.in_rdy), int'(!exp_ov || d_ordy));
        if (exp_ov && d_ordy) begin
          if (q.size() > 0) chk($sformatf("sf1 out_acc #%0d", got), int'(if_d.out_acc),
                                q.pop_front());
          got++;
        end
        acc_now = d_v && (!exp_ov || d_ordy);
        if (acc_now) begin
          q.push_back(val);
          sent++;
        end
        exp_ov = acc_now || (exp_ov && !d_ordy);
      end
      d_v    = 1'b0;
      d_ordy = 1'b1;
      chk("sf1 results delivered", got, 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mvu_pe_acc_ctrl.md
# mvu_pe_acc_ctrl

Fold sequencer and accumulator placed directly after the per-PE SIMD adder tree in the Matrix-Vector-Multiplication Unit. It accepts one adder-tree partial sum per beat over a valid/ready handshake and counts SF synaptic-fold beats. It accumulates those beats into a TO-bit signed register and presents the completed dot-product to the downstream output stage, holding it until accepted. Under back-pressure it stalls the upstream PE pipeline through `in_rdy`.

## Interface
- `TI`, 10: width of the adder-tree sum, signed.
- `TO`, 16: accumulator and output width, signed; TO >= TI.
- `SF`, 4: fold beats per output (synaptic fold); SF >= 1.
- `aclk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_v`  in  1  partial sum valid.
- `in_rdy`  out  1  block can accept a partial sum this cycle.
- `in_sum`  in  TI  signed partial sum from the adder tree.
- `out_v`  out  1  completed accumulation valid.
- `out_rdy`  in  1  downstream accepts `out_acc`.
- `out_acc`  out  TO  signed accumulated result.
- `fold_idx`  out  max(1,$clog2(SF))  index of the next beat to be accepted within the current fold.
- `busy`  out  1  high when `fold_idx`≠0 or `out_v`=1.

## Operation
- States: ACC (gathering beats) and OUT (result held). Reset state is ACC.
- `in_rdy` = (state==ACC) | `out_rdy`. Accept = `in_v` & `in_rdy`. Output handshake = `out_v` & `out_rdy`.
- On accept, `in_sum` is sign-extended to TO.
  - If `fold_idx`==0, acc <= ext(in_sum).
  - Otherwise, acc <= acc + ext(in_sum).
- On accept with `fold_idx`==SF-1: `fold_idx` <= 0 and next state is OUT. Otherwise `fold_idx` increments.
- In OUT with handshake and no accept, next state is ACC.
- In OUT, a handshake and an accept in the same cycle are legal.
  - The held result is consumed and the new beat starts the next fold, so acc is loaded rather than added to.
  - Next state is OUT only if that beat is also the last one, which happens only when SF==1. Otherwise next state is ACC.
- `out_acc` mirrors acc. It is stable while `out_v`=1 and `out_rdy`=0.
- `in_sum` is ignored whenever no accept occurs.
- SF==1: every accepted beat produces an output. Sustained throughput is one per cycle while `out_rdy`=1.
- Reset mid-fold discards the partial accumulation and any held result. No output is emitted for the aborted fold.
- Reset values: `out_v`=0, `out_acc`=0, `fold_idx`=0, `busy`=0, `in_rdy`=1, state ACC.

## Timing
- `out_v` rises the cycle after the last beat of a fold is accepted, so latency is 1 cycle from the last accept.
- No bubble between folds while `out_rdy`=1. SF beats in, one result out, every SF cycles.
- `in_rdy` depends combinationally on `out_rdy` and on registered state only. There is no combinational path from `in_v` to `in_rdy`.
- `out_v` and `out_acc` are registered outputs.

## Configuration
- `MVU_PE_ACC_SAT_EN` defined: each addition clamps to the signed TO range.
  - Positive overflow gives 2^(TO-1)-1.
  - Negative overflow gives -2^(TO-1).
- Not defined: additions wrap modulo 2^TO with two's-complement arithmetic and no overflow detection.

## Structure
- Shared package `mvu_pkg` holds:
  - the state typedef `mvu_acc_state_t` {ACC, OUT};
  - the width function for `fold_idx`.
- One sub-module: `mvu_pe_acc_add`, a TO-bit signed adder. It contains the saturating variant under `MVU_PE_ACC_SAT_EN` and the plain wrap adder otherwise.

## Test plan
- Basic fold: TI=10, TO=16, SF=4, `out_rdy`=1, `in_sum` 1,2,3,4 on consecutive cycles.
  - Required: `out_v`=1 for one cycle, one cycle after the 4th beat, with `out_acc`=10.
  - Required: the next fold starts with no bubble.
- Back-pressure: hold `out_rdy`=0 for 5 cycles after a result.
  - Required: `in_rdy`=0, `out_acc` stable, no beats lost.
  - Required: the next fold 5,5,5,5 gives 20 after release.
- Negative and sign-extension: `in_sum`=-512 ×4.
  - Required: `out_acc`=-2048.
- Overflow: TO=12, `in_sum`=511 ×4 (sum 2044), then -512 ×4 (sum -2048). Both sums fit in 12 bits.
  - Then TO=11, `in_sum`=511 ×4. With `MVU_PE_ACC_SAT_EN` the required result is 1023; without it, -4.
- SF=1 streaming: 8 beats with random `out_rdy`.
  - Required: each output equals its input, in order.
  - Required: simultaneous handshake and accept works, no drops or duplicates.
- Reset mid-fold: assert `rst` after 2 of 4 beats.
  - Required: `fold_idx`=0 and `out_v`=0.
  - Required: the next 4 beats 1,1,1,1 give exactly 4.
